battle_front: RTL and testbench
===============================

Name: battle_front

Overview:
- Battlefield front-line locator for the game logic.
- Scans 16 friendly and 16 enemy unit slots and finds the front-most live unit on each side: leftmost friendly, rightmost enemy.
- Reports each side's front position with a fixed engagement offset applied, plus the slot index of that unit (the unit that takes damage).
- Start/Done/Ack handshake with the battle controller; inputs are held stable from Start until Done.

Parameters:
- FRIENDLY_OFFSET, 6, subtracted from the leftmost friendly location.
- ENEMY_OFFSET, 7, added to the rightmost enemy location.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  begin a scan; honoured only in INI.
- Ack  input  1  acknowledge result; honoured only in DONE.
- unitLoc0..unitLoc15  input  9 each  friendly slot x-position, 0..511.
- unitType0..unitType15  input  2 each  friendly slot type; 0 = empty slot, 1..3 = live unit.
- enemyLoc0..enemyLoc15  input  9 each  enemy slot x-position.
- enemyType0..enemyType15  input  2 each  enemy slot type; 0 = empty.
- friendlyFront  output  9  min live friendly loc minus FRIENDLY_OFFSET.
- enemyFront  output  9  max live enemy loc plus ENEMY_OFFSET.
- unitDamageSelect  output  5  index 0..15 of the front friendly unit; 16 = none.
- enemyDamageSelect  output  5  index 0..15 of the front enemy unit; 16 = none.
- Done  output  1  result valid.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- FSM states are INI, SCAN and DONE; rst forces INI from any state, including mid-scan, and discards any partial result.
- Reset values of outputs: friendlyFront=0, enemyFront=0, unitDamageSelect=16, enemyDamageSelect=16, Done=0.
- INI: on Start=1, clear the working registers and go to SCAN with index=0:
  - friendly best loc = 511, friendly found = 0, friendly best index = 16;
  - enemy best loc = 0, enemy found = 0, enemy best index = 16.
- SCAN, one slot per clock at index i:
  - friendly slot i counts when unitType i ≠ 0 and either (nothing found yet) or (loc < best loc). Strict compare, so on a tie the lowest index wins.
  - enemy slot i counts when enemyType i ≠ 0 and either (nothing found yet) or (loc > best loc). Strict compare, lowest index wins on a tie.
  - After i=15, go to DONE and register the outputs in the same edge.
- Output computation:
  - friendlyFront = best friendly loc − FRIENDLY_OFFSET.
  - enemyFront = best enemy loc + ENEMY_OFFSET.
  - No live friendly: friendlyFront=0, unitDamageSelect=16.
  - No live enemy: enemyFront=511, enemyDamageSelect=16.
- Latency: Done rises 16 clocks after the edge that samples Start.
- DONE: Done=1. On Ack=1, go to INI; Done drops on the next edge.
- Outputs hold their last values until the next completed scan.
- Start outside INI is ignored; Ack outside DONE is ignored.
- Arithmetic is 9-bit; overflow handling is set by the optional feature.

Optional Feature:
- Macro: BATTLEFRONT_SATURATE_EN.
- Defined: the subtraction clamps at 0 and the addition clamps at 511; e.g. friendly loc 3 gives 0, enemy loc 508 gives 511.
- Undefined: plain 9-bit modulo-512 wrap; e.g. loc 3 gives 509, loc 508 gives 3.

Test Plan:
- Setup for all scans: locs 0,32,64,128,160,192,224,256,288,320,352,384,416,448,480,511 on both sides.
- All types 0 -> Done asserted; friendlyFront=0, enemyFront=511, both selects=16; takes 16 clocks.
- Only unit14=1 (loc 480) and enemy1=1 (loc 32) -> friendlyFront=474, enemyFront=39, unitDamageSelect=14, enemyDamageSelect=1.
- Add unit2=2 (loc 64) and enemy14=2 (loc 480) -> friendlyFront=58, enemyFront=487, unitDamageSelect=2, enemyDamageSelect=14.
- Units 3 and 7 both at loc 100, live; enemies 5 and 9 both at loc 300, live -> unitDamageSelect=3, enemyDamageSelect=5.
- Handshake: Done stays high for 10 clocks without Ack; Start pulses during SCAN and DONE are ignored; Ack -> Done low next edge; a new Start scans again.
- rst asserted mid-SCAN -> next cycle in INI with Done=0 and outputs at reset values; a subsequent Start gives a correct result.

Source files
------------

// File: rtl/battle_front.sv
// Front-line locator: leftmost live friendly and rightmost live enemy, one slot per clock.
// Optional BATTLEFRONT_SATURATE_EN clamps the offset arithmetic instead of wrapping.
module battle_front #(
    parameter int FRIENDLY_OFFSET = 6,
    parameter int ENEMY_OFFSET    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Ack,
    input  logic [8:0] unitLoc0,
    input  logic [8:0] unitLoc1,
    input  logic [8:0] unitLoc2,
    input  logic [8:0] unitLoc3,
    input  logic [8:0] unitLoc4,
    input  logic [8:0] unitLoc5,
    input  logic [8:0] unitLoc6,
    input  logic [8:0] unitLoc7,
    input  logic [8:0] unitLoc8,
    input  logic [8:0] unitLoc9,
    input  logic [8:0] unitLoc10,
    input  logic [8:0] unitLoc11,
    input  logic [8:0] unitLoc12,
    input  logic [8:0] unitLoc13,
    input  logic [8:0] unitLoc14,
    input  logic [8:0] unitLoc15,
    input  logic [1:0] unitType0,
    input  logic [1:0] unitType1,
    input  logic [1:0] unitType2,
    input  logic [1:0] unitType3,
    input  logic [1:0] unitType4,
    input  logic [1:0] unitType5,
    input  logic [1:0] unitType6,
    input  logic [1:0] unitType7,
    input  logic [1:0] unitType8,
    input  logic [1:0] unitType9,
    input  logic [1:0] unitType10,
    input  logic [1:0] unitType11,
    input  logic [1:0] unitType12,
    input  logic [1:0] unitType13,
    input  logic [1:0] unitType14,
    input  logic [1:0] unitType15,
    input  logic [8:0] enemyLoc0,
    input  logic [8:0] enemyLoc1,
    input  logic [8:0] enemyLoc2,
    input  logic [8:0] enemyLoc3,
    input  logic [8:0] enemyLoc4,
    input  logic [8:0] enemyLoc5,
    input  logic [8:0] enemyLoc6,
    input  logic [8:0] enemyLoc7,
    input  logic [8:0] enemyLoc8,
    input  logic [8:0] enemyLoc9,
    input  logic [8:0] enemyLoc10,
    input  logic [8:0] enemyLoc11,
    input  logic [8:0] enemyLoc12,
    input  logic [8:0] enemyLoc13,
    input  logic [8:0] enemyLoc14,
    input  logic [8:0] enemyLoc15,
    input  logic [1:0] enemyType0,
    input  logic [1:0] enemyType1,
    input  logic [1:0] enemyType2,
    input  logic [1:0] enemyType3,
    input  logic [1:0] enemyType4,
    input  logic [1:0] enemyType5,
    input  logic [1:0] enemyType6,
    input  logic [1:0] enemyType7,
    input  logic [1:0] enemyType8,
    input  logic [1:0] enemyType9,
    input  logic [1:0] enemyType10,
    input  logic [1:0] enemyType11,
    input  logic [1:0] enemyType12,
    input  logic [1:0] enemyType13,
    input  logic [1:0] enemyType14,
    input  logic [1:0] enemyType15,
    output logic [8:0] friendlyFront,
    output logic [8:0] enemyFront,
    output logic [4:0] unitDamageSelect,
    output logic [4:0] enemyDamageSelect,
    output logic       Done
);

    localparam logic [8:0] FOFF = 9'(FRIENDLY_OFFSET);
    localparam logic [8:0] EOFF = 9'(ENEMY_OFFSET);

    typedef enum logic [1:0] {INI, SCAN, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_idx;
    logic [8:0] r_uBest;
    logic       r_uFound;
    logic [4:0] r_uIdx;
    logic [8:0] r_eBest;
    logic       r_eFound;
    logic [4:0] r_eIdx;

    logic [8:0] w_uLoc  [16];
    logic [1:0] w_uType [16];
    logic [8:0] w_eLoc  [16];
    logic [1:0] w_eType [16];

    assign w_uLoc = '{unitLoc0, unitLoc1, unitLoc2, unitLoc3,
                      unitLoc4, unitLoc5, unitLoc6, unitLoc7,
                      unitLoc8, unitLoc9, unitLoc10, unitLoc11,
                      unitLoc12, unitLoc13, unitLoc14, unitLoc15};
    assign w_uType = '{unitType0, unitType1, unitType2, unitType3,
                       unitType4, unitType5, unitType6, unitType7,
                       unitType8, unitType9, unitType10, unitType11,
                       unitType12, unitType13, unitType14, unitType15};
    assign w_eLoc = '{enemyLoc0, enemyLoc1, enemyLoc2, enemyLoc3,
                      enemyLoc4, enemyLoc5, enemyLoc6, enemyLoc7,
                      enemyLoc8, enemyLoc9, enemyLoc10, enemyLoc11,
                      enemyLoc12, enemyLoc13, enemyLoc14, enemyLoc15};
    assign w_eType = '{enemyType0, enemyType1, enemyType2, enemyType3,
                       enemyType4, enemyType5, enemyType6, enemyType7,
                       enemyType8, enemyType9, enemyType10, enemyType11,
                       enemyType12, enemyType13, enemyType14, enemyType15};

    logic       w_uTake;
    logic       w_eTake;
    logic [8:0] w_uBestNx;
    logic       w_uFoundNx;
    logic [4:0] w_uIdxNx;
    logic [8:0] w_eBestNx;
    logic       w_eFoundNx;
    logic [4:0] w_eIdxNx;
    logic [8:0] w_fFront;
    logic [8:0] w_eFront;

    // Strict compares keep the lowest index on a tie.
    always_comb begin
        w_uTake    = (w_uType[r_idx] != 2'd0) &&
                     (!r_uFound || (w_uLoc[r_idx] < r_uBest));
        w_eTake    = (w_eType[r_idx] != 2'd0) &&
                     (!r_eFound || (w_eLoc[r_idx] > r_eBest));
        w_uBestNx  = w_uTake ? w_uLoc[r_idx] : r_uBest;
        w_uFoundNx = r_uFound | w_uTake;
        w_uIdxNx   = w_uTake ? {1'b0, r_idx} : r_uIdx;
        w_eBestNx  = w_eTake ? w_eLoc[r_idx] : r_eBest;
        w_eFoundNx = r_eFound | w_eTake;
        w_eIdxNx   = w_eTake ? {1'b0, r_idx} : r_eIdx;
    end

    always_comb begin
`ifdef BATTLEFRONT_SATURATE_EN
        w_fFront = (w_uBestNx < FOFF) ? 9'd0 : w_uBestNx - FOFF;
        w_eFront = (w_eBestNx > 9'd511 - EOFF) ? 9'd511 : w_eBestNx + EOFF;
`else
        w_fFront = w_uBestNx - FOFF;
        w_eFront = w_eBestNx + EOFF;
`endif
        if (!w_uFoundNx) w_fFront = 9'd0;
        if (!w_eFoundNx) w_eFront = 9'd511;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= INI;
            r_idx             <= 4'd0;
            r_uBest           <= 9'd511;
            r_uFound          <= 1'b0;
            r_uIdx            <= 5'd16;
            r_eBest           <= 9'd0;
            r_eFound          <= 1'b0;
            r_eIdx            <= 5'd16;
            friendlyFront     <= 9'd0;
            enemyFront        <= 9'd0;
            unitDamageSelect  <= 5'd16;
            enemyDamageSelect <= 5'd16;
            Done              <= 1'b0;
        end else begin
            unique case (r_state)
                INI: begin
                    if (Start) begin
                        r_state  <= SCAN;
                        r_idx    <= 4'd0;
                        r_uBest  <= 9'd511;
                        r_uFound <= 1'b0;
                        r_uIdx   <= 5'd16;
                        r_eBest  <= 9'd0;
                        r_eFound <= 1'b0;
                        r_eIdx   <= 5'd16;
                    end
                end
                SCAN: begin
                    r_uBest  <= w_uBestNx;
                    r_uFound <= w_uFoundNx;
                    r_uIdx   <= w_uIdxNx;
                    r_eBest  <= w_eBestNx;
                    r_eFound <= w_eFoundNx;
                    r_eIdx   <= w_eIdxNx;
                    r_idx    <= r_idx + 4'd1;
                    if (r_idx == 4'd15) begin
                        r_state           <= DONE;
                        friendlyFront     <= w_fFront;
                        enemyFront        <= w_eFront;
                        unitDamageSelect  <= w_uIdxNx;
                        enemyDamageSelect <= w_eIdxNx;
                        Done              <= 1'b1;
                    end
                end
                DONE: begin
                    if (Ack) begin
                        r_state <= INI;
                        Done    <= 1'b0;
                    end
                end
                default: r_state <= INI;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_front.sv
// Scoreboard bench for battle_front: a reference model pushes expected results,
// a monitor pops and compares them on each rising Done.
module tb_battle_front;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start;
    logic       Ack;
    logic [8:0] uloc [16];
    logic [1:0] ut   [16];
    logic [8:0] eloc [16];
    logic [1:0] et   [16];
    logic [8:0] friendlyFront;
    logic [8:0] enemyFront;
    logic [4:0] unitDamageSelect;
    logic [4:0] enemyDamageSelect;
    logic       Done;

    typedef struct {
        logic [8:0] ff;
        logic [8:0] ef;
        logic [4:0] us;
        logic [4:0] es;
        int         dcyc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prevDone = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    battle_front dut (
        .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
        .unitLoc0(uloc[0]),   .unitLoc1(uloc[1]),   .unitLoc2(uloc[2]),   .unitLoc3(uloc[3]),
        .unitLoc4(uloc[4]),   .unitLoc5(uloc[5]),   .unitLoc6(uloc[6]),   .unitLoc7(uloc[7]),
        .unitLoc8(uloc[8]),   .unitLoc9(uloc[9]),   .unitLoc10(uloc[10]), .unitLoc11(uloc[11]),
        .unitLoc12(uloc[12]), .unitLoc13(uloc[13]), .unitLoc14(uloc[14]), .unitLoc15(uloc[15]),
        .unitType0(ut[0]),    .unitType1(ut[1]),    .unitType2(ut[2]),    .unitType3(ut[3]),
        .unitType4(ut[4]),    .unitType5(ut[5]),    .unitType6(ut[6]),    .unitType7(ut[7]),
        .unitType8(ut[8]),    .unitType9(ut[9]),    .unitType10(ut[10]),  .unitType11(ut[11]),
        .unitType12(ut[12]),  .unitType13(ut[13]),  .unitType14(ut[14]),  .unitType15(ut[15]),
        .enemyLoc0(eloc[0]),   .enemyLoc1(eloc[1]),   .enemyLoc2(eloc[2]),   .enemyLoc3(eloc[3]),
        .enemyLoc4(eloc[4]),   .enemyLoc5(eloc[5]),   .enemyLoc6(eloc[6]),   .enemyLoc7(eloc[7]),
        .enemyLoc8(eloc[8]),   .enemyLoc9(eloc[9]),   .enemyLoc10(eloc[10]), .enemyLoc11(eloc[11]),
        .enemyLoc12(eloc[12]), .enemyLoc13(eloc[13]), .enemyLoc14(eloc[14]), .enemyLoc15(eloc[15]),
        .enemyType0(et[0]),   .enemyType1(et[1]),   .enemyType2(et[2]),   .enemyType3(et[3]),
        .enemyType4(et[4]),   .enemyType5(et[5]),   .enemyType6(et[6]),   .enemyType7(et[7]),
        .enemyType8(et[8]),   .enemyType9(et[9]),   .enemyType10(et[10]), .enemyType11(et[11]),
        .enemyType12(et[12]), .enemyType13(et[13]), .enemyType14(et[14]), .enemyType15(et[15]),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront),
        .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
        .Done(Done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fsub(input int m);
`ifdef BATTLEFRONT_SATURATE_EN
        return (m < 6) ? 0 : m - 6;
`else
        return (m - 6 + 512) % 512;
`endif
    endfunction

    function automatic int eadd(input int m);
`ifdef BATTLEFRONT_SATURATE_EN
        return (m + 7 > 511) ? 511 : m + 7;
`else
        return (m + 7) % 512;
`endif
    endfunction

    // Find the extreme value first, then the lowest slot holding it.
    function automatic exp_t model(input int dc);
        exp_t r;
        int   mn = 512;
        int   mx = -1;
        int   v;
        r.us = 5'd16;
        r.es = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (ut[i] != 0) begin v = uloc[i]; if (v < mn) mn = v; end
            if (et[i] != 0) begin v = eloc[i]; if (v > mx) mx = v; end
        end
        for (int i = 15; i >= 0; i--) begin
            v = uloc[i];
            if (ut[i] != 0 && v == mn) r.us = 5'(i);
            v = eloc[i];
            if (et[i] != 0 && v == mx) r.es = 5'(i);
        end
        r.ff   = (r.us == 16) ? 9'd0 : 9'(fsub(mn));
        r.ef   = (r.es == 16) ? 9'd511 : 9'(eadd(mx));
        r.dcyc = dc;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && Done && !prevDone) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("friendlyFront", int'(friendlyFront), int'(mon_e.ff));
                chk("enemyFront", int'(enemyFront), int'(mon_e.ef));
                chk("unitDamageSelect", int'(unitDamageSelect), int'(mon_e.us));
                chk("enemyDamageSelect", int'(enemyDamageSelect), int'(mon_e.es));
                chk("latency_cycle", cyc, mon_e.dcyc);
            end
        end
        prevDone = Done;
    end

    task automatic setup_locs();
        int locs [16] = '{0, 32, 64, 128, 160, 192, 224, 256,
                          288, 320, 352, 384, 416, 448, 480, 511};
        for (int i = 0; i < 16; i++) begin
            uloc[i] = 9'(locs[i]);
            eloc[i] = 9'(locs[i]);
            ut[i]   = 2'd0;
            et[i]   = 2'd0;
        end
    endtask

    task automatic randomize_slots();
        int mode = $urandom_range(0, 2);
        int pick;
        for (int i = 0; i < 16; i++) begin
            pick = $urandom_range(0, 11);
            if (mode == 0)      uloc[i] = 9'($urandom_range(0, 511));
            else if (mode == 1) uloc[i] = 9'((pick < 6) ? pick : 500 + pick);
            else                uloc[i] = 9'(100 + 50 * (pick % 3));
            pick = $urandom_range(0, 11);
            if (mode == 0)      eloc[i] = 9'($urandom_range(0, 511));
            else if (mode == 1) eloc[i] = 9'((pick < 6) ? pick : 500 + pick);
            else                eloc[i] = 9'(100 + 50 * (pick % 3));
            ut[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            et[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        end
    endtask

    // Called right after a falling edge; Start/Ack pulses outside their states are noise.
    task automatic run_scan(input int hold);
        int n = 0;
        last = model(cyc + 17);
        q.push_back(last);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        while (!Done && n < 40) begin
            Start = (n == 5);
            Ack   = (n == 8);
            @(negedge clk);
            n++;
        end
        Start = 1'b0;
        Ack   = 1'b0;
        if (!Done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            Start = (k == 2);
            @(negedge clk);
            chk("done_hold", int'(Done), 1);
        end
        Start = 1'b0;
        Ack   = 1'b1;
        @(negedge clk);
        Ack = 1'b0;
        chk("done_after_ack", int'(Done), 0);
        chk("ff_holds", int'(friendlyFront), int'(last.ff));
        chk("us_holds", int'(unitDamageSelect), int'(last.us));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_Done"}, int'(Done), 0);
        chk({tag, "_ff"}, int'(friendlyFront), 0);
        chk({tag, "_ef"}, int'(enemyFront), 0);
        chk({tag, "_us"}, int'(unitDamageSelect), 16);
        chk({tag, "_es"}, int'(enemyDamageSelect), 16);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        Start = 1'b0;
        Ack   = 1'b0;
        setup_locs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        run_scan(10);
        ut[14] = 2'd1;
        et[1]  = 2'd1;
        run_scan(3);
        ut[2]  = 2'd2;
        et[14] = 2'd2;
        run_scan(1);
        setup_locs();
        uloc[3] = 9'd100; uloc[7] = 9'd100; ut[3] = 2'd1; ut[7] = 2'd1;
        eloc[5] = 9'd300; eloc[9] = 9'd300; et[5] = 2'd1; et[9] = 2'd1;
        run_scan(0);

        randomize_slots();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midscan_reset");
        repeat (20) @(negedge clk);
        chk("no_done_after_reset", int'(Done), 0);
        run_scan(2);

        for (int t = 0; t < 30; t++) begin
            randomize_slots();
            run_scan($urandom_range(0, 4));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
